// File: rtl/ro_puf_pkg.sv
// ---------------------------------------------------------------------------
// ro_puf_pkg
// Purpose : shared definitions for the RO-PUF pair meter and the response
//           collector that sits behind it: the measurement FSM encoding and
//           the default build-time parameter values.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package ro_puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COUNT   = 2'd2,
        ST_COMPARE = 2'd3
    } ro_state_e;

    localparam int RO_PUF_NUM_RO     = 16;
    localparam int RO_PUF_CNT_W      = 16;
    localparam int RO_PUF_WINDOW     = 1024;
    localparam int RO_PUF_SETTLE_CYC = 8;

endpackage

// File: rtl/ro_edge_counter.sv
// ---------------------------------------------------------------------------
// ro_edge_counter
// Purpose : counts rising edges of one asynchronous oscillator signal.
//           The input passes a 2-FF synchronizer, a third flop provides the
//           previous value for edge detection, and a saturating counter
//           accumulates edges while enabled.
// Ports   : clk, reset  - clock, async active-high reset
//           ro_in       - raw oscillator output (async to clk)
//           clr         - synchronous clear of the count (priority over en)
//           en          - count detected rising edges
//           cnt         - current edge count, sticks at all-ones
//           sat         - count has reached its ceiling
// ---------------------------------------------------------------------------
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = RO_PUF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    // The counter stops at all-ones rather than wrapping, so a fast
    // oscillator can never alias to a small count.
    always_comb begin
        sync1_d = ro_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    // The count only leaves all-ones through clr, so this is sticky per run.
    assign cnt = cnt_q;
    assign sat = &cnt_q;

endmodule

// File: rtl/ro_puf_pair_meter.sv
// ---------------------------------------------------------------------------
// ro_puf_pair_meter
// Purpose : RO-PUF measurement engine. Enables the RO bank, lets it settle,
//           counts rising edges of the two challenge-selected oscillators for
//           a fixed clk window, compares the counts and returns one bit.
// Ports   : clk, reset    - clock, async active-high reset
//           ro_in         - raw oscillator outputs from the RO bank
//           ro_en         - RO bank enable (high only in SETTLE/COUNT)
//           start         - measurement request, honoured only in IDLE
//           sel_a, sel_b  - challenge: the two oscillator indices
//           abort         - cancel a measurement in SETTLE/COUNT
//           busy          - measurement in progress
//           done          - one-cycle pulse, result outputs just updated
//           resp          - cnt_a > cnt_b
//           tie           - cnt_a == cnt_b
//           sat           - either counter hit its ceiling
//           err           - illegal challenge (equal or out-of-range index)
//           cnt_a, cnt_b  - final edge counts of the selected oscillators
// ---------------------------------------------------------------------------
module ro_puf_pair_meter
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO     = RO_PUF_NUM_RO,
    parameter int SEL_W      = $clog2(NUM_RO),
    parameter int CNT_W      = RO_PUF_CNT_W,
    parameter int WINDOW     = RO_PUF_WINDOW,
    parameter int SETTLE_CYC = RO_PUF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_RO-1:0] ro_in,
    output logic              ro_en,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              resp,
    output logic              tie,
    output logic              sat,
    output logic              err,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    // One phase counter serves both SETTLE and COUNT.
    localparam int PH_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    ro_state_e        state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    logic             ro_en_q, ro_en_d;
    logic             done_q, done_d;
    logic             resp_q, resp_d;
    logic             tie_q, tie_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic             ro_a, ro_b;
    logic             sel_legal;
    logic             cnt_clr, cnt_en;
    logic [CNT_W-1:0] ec_cnt_a, ec_cnt_b;
    logic             ec_sat_a, ec_sat_b;

    // Selection muxes are driven from the latched challenge so the
    // synchronizers see a stable source for the whole measurement.
    always_comb begin
        ro_a = 1'b0;
        ro_b = 1'b0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (sel_a_q == SEL_W'(i)) ro_a = ro_in[i];
            if (sel_b_q == SEL_W'(i)) ro_b = ro_in[i];
        end
    end

    // The index fields may be wider than NUM_RO needs, so range is checked.
    assign sel_legal = (sel_a != sel_b) &&
                       (32'(sel_a) < 32'(NUM_RO)) &&
                       (32'(sel_b) < 32'(NUM_RO));

    assign cnt_clr = (state_q == ST_SETTLE);
    assign cnt_en  = (state_q == ST_COUNT);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .reset (reset),
        .ro_in (ro_a),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (ec_cnt_a),
        .sat   (ec_sat_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .reset (reset),
        .ro_in (ro_b),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (ec_cnt_b),
        .sat   (ec_sat_b)
    );

    // Next-state and result logic. Result registers only change on a done
    // event, so an abort leaves the previous result visible.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        done_d  = 1'b0;
        resp_d  = resp_q;
        tie_d   = tie_q;
        sat_d   = sat_q;
        err_d   = err_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_a_d = sel_a;
                    sel_b_d = sel_b;
                    if (sel_legal) begin
                        state_d = ST_SETTLE;
                        ph_d    = '0;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        resp_d  = 1'b0;
                        tie_d   = 1'b0;
                        sat_d   = 1'b0;
                        cnt_a_d = '0;
                        cnt_b_d = '0;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_COUNT;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (ph_q == PH_W'(WINDOW - 1)) begin
                    state_d = ST_COMPARE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_COMPARE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                resp_d  = (ec_cnt_a > ec_cnt_b);
                tie_d   = (ec_cnt_a == ec_cnt_b);
                sat_d   = ec_sat_a | ec_sat_b;
                err_d   = 1'b0;
                cnt_a_d = ec_cnt_a;
                cnt_b_d = ec_cnt_b;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so the enable into the RO bank is glitch-free.
        ro_en_d = (state_d == ST_SETTLE) || (state_d == ST_COUNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            ro_en_q <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= 1'b0;
            tie_q   <= 1'b0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            ro_en_q <= ro_en_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign ro_en = ro_en_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign resp  = resp_q;
    assign tie   = tie_q;
    assign sat   = sat_q;
    assign err   = err_q;
    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;

endmodule
